// File: rtl/dma_copy.sv
// rtl/dma_copy.sv - single-channel word copy engine: read a source word, write it to the destination, repeat
module dma_copy #(
    parameter int AW = 16,
    parameter int LW = 9
) (
    input  logic          cpu_clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] dst,
    input  logic [LW-1:0] len,
    output logic          bus_req,
    input  logic          bus_gnt,
    output logic [AW-1:0] adrs,
    output logic          we,
    output logic [15:0]   to_mem,
    output logic          drive,
    input  logic [15:0]   from_mem,
    output logic          busy,
    output logic          done,
    output logic [LW-1:0] remaining
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] REQ  = 3'd1;
    localparam logic [2:0] RADR = 3'd2;
    localparam logic [2:0] RCAP = 3'd3;
    localparam logic [2:0] WR   = 3'd4;
    localparam logic [2:0] FIN  = 3'd5;

    logic [2:0]    state;
    logic [AW-1:0] src_ptr;
    logic [AW-1:0] dst_ptr;
    logic [LW-1:0] rem;
    logic [15:0]   data;
    // abort may arrive mid-word; remember it until the next word boundary
    logic          abort_pend;

    // copy sequencer: pointers, word count, captured data and pending abort
    always_ff @(posedge cpu_clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            src_ptr    <= '0;
            dst_ptr    <= '0;
            rem        <= '0;
            data       <= '0;
            abort_pend <= 1'b0;
        end else begin
            if (abort && (state == RADR || state == RCAP)) begin
                abort_pend <= 1'b1;
            end
            case (state)
                IDLE: begin
                    abort_pend <= 1'b0;
                    if (start) begin
                        src_ptr <= src;
                        dst_ptr <= dst;
                        rem     <= len;
                        state   <= (len == '0) ? FIN : REQ;
                    end
                end
                REQ: begin
                    if (abort || abort_pend) begin
                        state <= FIN;
                    end else if (bus_gnt) begin
                        state <= RADR;
                    end
                end
                RADR: state <= RCAP;
                RCAP: begin
                    data  <= from_mem;
                    state <= WR;
                end
                WR: begin
                    src_ptr <= src_ptr + 1'b1;
                    dst_ptr <= dst_ptr + 1'b1;
                    rem     <= rem - 1'b1;
                    if (rem == LW'(1) || abort || abort_pend) begin
                        state <= FIN;
                    end else if (!bus_gnt) begin
                        state <= REQ;
                    end else begin
                        state <= RADR;
                    end
                end
                FIN: begin
                    abort_pend <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // bus outputs decode from state only, so reset clears them without waiting for a clock
    always_comb begin
        drive   = (state == RADR) || (state == RCAP) || (state == WR);
        we      = (state == WR);
        bus_req = (state == REQ) || drive;
        adrs    = '0;
        to_mem  = '0;
        if (state == RADR || state == RCAP) begin
            adrs = src_ptr;
        end else if (state == WR) begin
            adrs   = dst_ptr;
            to_mem = data;
        end
        busy      = (state != IDLE);
        done      = (state == FIN);
        remaining = rem;
    end

endmodule

// File: tb/tb_dma_copy.sv
// tb/tb_dma_copy.sv - directed scoreboard bench for dma_copy against a registered-read memory model
module tb_dma_copy;

    logic        cpu_clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] src = '0;
    logic [15:0] dst = '0;
    logic [8:0]  len = '0;
    logic        bus_req;
    logic        bus_gnt = 1'b1;
    logic [15:0] adrs;
    logic        we;
    logic [15:0] to_mem;
    logic        drive;
    logic [15:0] from_mem = '0;
    logic        busy;
    logic        done;
    logic [8:0]  remaining;

    int tests = 0;
    int fails = 0;
    int drive_cnt = 0;
    int k;
    logic [15:0] mem [int];
    logic [31:0] exp_q [$];
    logic [31:0] got;

    dma_copy #(.AW(16), .LW(9)) dut (
        .cpu_clk(cpu_clk), .rst(rst), .start(start), .abort(abort),
        .src(src), .dst(dst), .len(len),
        .bus_req(bus_req), .bus_gnt(bus_gnt), .adrs(adrs), .we(we),
        .to_mem(to_mem), .drive(drive), .from_mem(from_mem),
        .busy(busy), .done(done), .remaining(remaining)
    );

    always #5 cpu_clk = ~cpu_clk;

    // memory model: unmapped addresses answer with a pattern derived from the address
    always @(posedge cpu_clk) begin
        if (drive && we) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $error("FAIL unexpected_write observed=%0h:%0h expected=none", adrs, to_mem);
            end else begin
                got = exp_q.pop_front();
                assert ({adrs, to_mem} === got) else begin
                    fails++;
                    $error("FAIL write observed=%0h expected=%0h", {adrs, to_mem}, got);
                end
            end
            mem[int'(adrs)] = to_mem;
        end
        from_mem <= mem.exists(int'(adrs)) ? mem[int'(adrs)] : (adrs ^ 16'h5A5A);
    end

    // we must never be asserted without drive
    always @(negedge cpu_clk) begin
        if (drive) drive_cnt++;
        tests++;
        assert (!(we && !drive)) else begin
            fails++;
            $error("FAIL we_without_drive observed=%0b expected=0", we);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic kick(input logic [15:0] s, input logic [15:0] d, input logic [8:0] l, input logic ab);
        start = 1'b1; src = s; dst = d; len = l; abort = ab;
        @(negedge cpu_clk);
        start = 1'b0; abort = 1'b0;
        k = 1;
    endtask

    task automatic wait_done();
        while (!done && k < 200) begin
            @(negedge cpu_clk);
            k++;
        end
        chk("done_seen", {31'd0, done}, 32'd1);
    endtask

    task automatic push(input logic [15:0] a, input logic [15:0] d);
        exp_q.push_back({a, d});
    endtask

    initial begin
        mem[16'h0010] = 16'h00A1; mem[16'h0011] = 16'h00B2;
        mem[16'h0012] = 16'h00C3; mem[16'h0013] = 16'h00D4;
        mem[16'h0200] = 16'h1111; mem[16'h0201] = 16'h2222;
        mem[16'h0202] = 16'h3333; mem[16'h0203] = 16'h4444; mem[16'h0204] = 16'h5555;

        // reset state
        #1;
        chk("rst_outputs", {bus_req, drive, we, busy, done, adrs, to_mem, remaining}, 32'd0);
        @(negedge cpu_clk); @(negedge cpu_clk);
        rst = 1'b0;
        @(negedge cpu_clk);

        // three-word copy with grant held; abort alongside start is not yet meaningful
        push(16'h0100, 16'h00A1); push(16'h0101, 16'h00B2); push(16'h0102, 16'h00C3);
        kick(16'h0010, 16'h0100, 9'd3, 1'b1);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        wait_done();
        chk("t1_latency", k, 32'd11);
        chk("t1_remaining", {23'd0, remaining}, 32'd0);
        @(negedge cpu_clk);
        chk("t1_idle", {busy, done, bus_req, drive}, 32'd0);
        chk("t1_mem102", {16'd0, mem[16'h0102]}, 32'h00C3);

        // zero-length copy goes straight to FIN with no bus traffic
        drive_cnt = 0;
        kick(16'h0010, 16'h0180, 9'd0, 1'b0);
        wait_done();
        chk("t2_latency_le2", {31'd0, (k >= 1 && k <= 2)}, 32'd1);
        @(negedge cpu_clk);
        chk("t2_drive_never", drive_cnt, 32'd0);
        chk("t2_mem_untouched", {31'd0, mem.exists(16'h0180)}, 32'd0);

        // grant dropped during RCAP of word 1; a start while busy must be ignored
        push(16'h0700, 16'h00A1); push(16'h0701, 16'h00B2);
        push(16'h0702, 16'h00C3); push(16'h0703, 16'h00D4);
        kick(16'h0010, 16'h0700, 9'd4, 1'b0);
        @(negedge cpu_clk); k++;
        start = 1'b1; src = 16'h0000; dst = 16'h0800; len = 9'd7;
        @(negedge cpu_clk); k++;
        start = 1'b0;
        bus_gnt = 1'b0;
        @(negedge cpu_clk); k++;
        @(negedge cpu_clk); k++;
        chk("t3_back_in_req", {bus_req, drive, busy}, 32'b101);
        chk("t3_remaining_3", {23'd0, remaining}, 32'd3);
        @(negedge cpu_clk); @(negedge cpu_clk);
        chk("t3_still_req", {bus_req, drive}, 32'b10);
        bus_gnt = 1'b1;
        wait_done();
        chk("t3_remaining", {23'd0, remaining}, 32'd0);
        chk("t3_mem703", {16'd0, mem[16'h0703]}, 32'h00D4);
        @(negedge cpu_clk);

        // abort pulsed during RADR of word 2 of 5
        push(16'h0300, 16'h1111); push(16'h0301, 16'h2222);
        kick(16'h0200, 16'h0300, 9'd5, 1'b0);
        repeat (4) begin @(negedge cpu_clk); k++; end
        chk("t4_in_radr", {drive, we, adrs}, {2'b10, 16'h0201});
        abort = 1'b1;
        @(negedge cpu_clk); k++;
        abort = 1'b0;
        wait_done();
        chk("t4_latency", k, 32'd8);
        chk("t4_remaining", {23'd0, remaining}, 32'd3);
        @(negedge cpu_clk); @(negedge cpu_clk);
        chk("t4_word3_absent", {31'd0, mem.exists(16'h0302)}, 32'd0);

        // source pointer wraps from 0xFFFF to 0x0000 (both unmapped)
        push(16'h0400, 16'hFFFF ^ 16'h5A5A); push(16'h0401, 16'h0000 ^ 16'h5A5A);
        kick(16'hFFFF, 16'h0400, 9'd2, 1'b0);
        wait_done();
        chk("t5_latency", k, 32'd8);
        @(negedge cpu_clk);

        // reset during WR of word 2: outputs clear at once, no done, then a clean rerun
        push(16'h0500, 16'h00A1);
        kick(16'h0010, 16'h0500, 9'd3, 1'b0);
        repeat (6) begin @(negedge cpu_clk); k++; end
        chk("t6_in_wr2", {drive, we, adrs}, {2'b11, 16'h0501});
        rst = 1'b1;
        #1;
        chk("t6_rst_outputs", {bus_req, drive, we, busy, done, adrs, to_mem, remaining}, 32'd0);
        @(negedge cpu_clk);
        chk("t6_no_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        @(negedge cpu_clk);
        chk("t6_word2_absent", {31'd0, mem.exists(16'h0501)}, 32'd0);
        push(16'h0600, 16'h00A1); push(16'h0601, 16'h00B2); push(16'h0602, 16'h00C3);
        kick(16'h0010, 16'h0600, 9'd3, 1'b0);
        wait_done();
        chk("t6_rerun_latency", k, 32'd11);
        chk("t6_rerun_remaining", {23'd0, remaining}, 32'd0);
        @(negedge cpu_clk);

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
